pc_fetch_unit: RTL and testbench



---
 rtl/riscv_pc_pkg.sv | 19 +
 rtl/next_pc_calc.sv | 35 +++
 rtl/pc_fetch_unit.sv | 143 ++++++++++++++
 tb/tb_pc_fetch_unit.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pc_pkg.sv
// Shared PCSrc encodings, fetch FSM states and the NOP constant for the PC/fetch slice.
package riscv_pc_pkg;

  localparam logic [1:0] PC_PLUS4  = 2'b00;
  localparam logic [1:0] PC_BRANCH = 2'b01;
  localparam logic [1:0] PC_JALR   = 2'b10;
  localparam logic [1:0] PC_RSVD   = 2'b11;

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [2:0] {
    S_BOOT,
    S_REQ,
    S_WAIT,
    S_ISSUE,
    S_EXEC
  } state_t;

endpackage

// File: rtl/next_pc_calc.sv
// Combinational next-PC mux/adder. With PC_MISALIGN_TRAP_EN defined it also flags a
// selected target whose bit[1] is set; the low two bits of next_pc_c are always cleared.
module next_pc_calc
  import riscv_pc_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [XLEN-1:0] pc_i,
  input  logic [1:0]      pc_src_i,
  input  logic [XLEN-1:0] imm_i,
  input  logic [XLEN-1:0] jalr_target_i,
`ifdef PC_MISALIGN_TRAP_EN
  output logic            misalign_c,
`endif
  output logic [XLEN-1:0] next_pc_c
);

  logic [XLEN-1:0] raw_pc;

  always_comb begin
    raw_pc = pc_i + XLEN'(4);
    case (pc_src_i)
      PC_PLUS4, PC_RSVD: raw_pc = pc_i + XLEN'(4);
      PC_BRANCH:         raw_pc = pc_i + imm_i;
      PC_JALR:           raw_pc = jalr_target_i & ~XLEN'(1);
    endcase
  end

  assign next_pc_c = raw_pc & ~XLEN'(3);

`ifdef PC_MISALIGN_TRAP_EN
  assign misalign_c = raw_pc[1];
`endif

endmodule

// File: rtl/pc_fetch_unit.sv
// PC register and single-outstanding instruction fetch sequencer (boot, request, wait,
// issue, execute). Optional misaligned-target trap via PC_MISALIGN_TRAP_EN.
module pc_fetch_unit
  import riscv_pc_pkg::*;
#(
  parameter int unsigned     XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_VEC = XLEN'(32'h0000_0000),
  parameter logic [XLEN-1:0] TRAP_VEC  = XLEN'(32'h0000_0100)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [1:0]      pc_src,
  input  logic [XLEN-1:0] imm,
  input  logic [XLEN-1:0] jalr_target,
  input  logic            redirect_valid,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [31:0]     imem_rdata,
  output logic            inst_valid,
  output logic [31:0]     inst,
  output logic [XLEN-1:0] inst_pc,
  input  logic            inst_ready,
  output logic [XLEN-1:0] pc
`ifdef PC_MISALIGN_TRAP_EN
  ,
  output logic            misalign_trap
`endif
);

  state_t          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            req_q, req_d;
  logic            valid_q, valid_d;
  logic [31:0]     inst_q, inst_d;
  logic [XLEN-1:0] inst_pc_q, inst_pc_d;
  logic            trap_q, trap_d;
  logic [XLEN-1:0] next_pc;
  logic            misalign;

  next_pc_calc #(
    .XLEN(XLEN)
  ) u_next_pc (
    .pc_i         (pc_q),
    .pc_src_i     (pc_src),
    .imm_i        (imm),
    .jalr_target_i(jalr_target),
`ifdef PC_MISALIGN_TRAP_EN
    .misalign_c   (misalign),
`endif
    .next_pc_c    (next_pc)
  );

`ifndef PC_MISALIGN_TRAP_EN
  assign misalign = 1'b0;
`endif

  // Next-state and registered-output values; everything holds unless a state acts.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    req_d     = req_q;
    valid_d   = valid_q;
    inst_d    = inst_q;
    inst_pc_d = inst_pc_q;
    trap_d    = 1'b0;
    case (state_q)
      S_BOOT: begin
        state_d = S_REQ;
        req_d   = 1'b1;
      end
      S_REQ: begin
        if (imem_gnt) begin
          state_d = S_WAIT;
          req_d   = 1'b0;
        end
      end
      S_WAIT: begin
        if (imem_rvalid) begin
          state_d   = S_ISSUE;
          inst_d    = imem_rdata;
          inst_pc_d = pc_q;
          valid_d   = 1'b1;
        end
      end
      S_ISSUE: begin
        if (inst_ready) begin
          state_d = S_EXEC;
          valid_d = 1'b0;
        end
      end
      S_EXEC: begin
        if (redirect_valid) begin
          state_d = S_REQ;
          req_d   = 1'b1;
          pc_d    = misalign ? TRAP_VEC : next_pc;
          trap_d  = misalign;
        end
      end
      default: begin
        state_d = S_BOOT;
        req_d   = 1'b0;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_BOOT;
      pc_q      <= RESET_VEC;
      req_q     <= 1'b0;
      valid_q   <= 1'b0;
      inst_q    <= NOP;
      inst_pc_q <= RESET_VEC;
      trap_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      req_q     <= req_d;
      valid_q   <= valid_d;
      inst_q    <= inst_d;
      inst_pc_q <= inst_pc_d;
      trap_q    <= trap_d;
    end
  end

  assign imem_req   = req_q;
  assign imem_addr  = pc_q;
  assign pc         = pc_q;
  assign inst_valid = valid_q;
  assign inst       = inst_q;
  assign inst_pc    = inst_pc_q;

`ifdef PC_MISALIGN_TRAP_EN
  assign misalign_trap = trap_q;
`else
  logic unused_trap;
  assign unused_trap = trap_q;
`endif

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Randomized self-checking bench for pc_fetch_unit against an instruction-level PC model.
// Honours PC_MISALIGN_TRAP_EN when defined.
module tb_pc_fetch_unit;

  localparam logic [31:0] RESET_VEC = 32'h0000_0000;
  localparam logic [31:0] TRAP_VEC  = 32'h0000_0100;
  localparam logic [31:0] NOP_WORD  = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [1:0]  pc_src = 2'b00;
  logic [31:0] imm = '0;
  logic [31:0] jalr_target = '0;
  logic        redirect_valid = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_ready = 1'b0;
  logic [31:0] pc;
`ifdef PC_MISALIGN_TRAP_EN
  logic        misalign_trap;
`endif

  int errors = 0;
  int checks = 0;
  logic [31:0] model_pc;
  logic        model_trap;

  pc_fetch_unit #(
    .XLEN(32), .RESET_VEC(RESET_VEC), .TRAP_VEC(TRAP_VEC)
  ) dut (
    .clk(clk), .rst_n(rst_n), .pc_src(pc_src), .imm(imm), .jalr_target(jalr_target),
    .redirect_valid(redirect_valid), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc), .inst_ready(inst_ready),
    .pc(pc)
`ifdef PC_MISALIGN_TRAP_EN
    , .misalign_trap(misalign_trap)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Architectural next-PC rule: select, then trap or word-align.
  function automatic logic [31:0] model_next(input logic [31:0] cur, input logic [1:0] src,
                                             input logic [31:0] im, input logic [31:0] jt,
                                             output logic trap);
    logic [31:0] t;
    if (src == 2'd1)      t = cur + im;
    else if (src == 2'd2) t = {jt[31:1], 1'b0};
    else                  t = cur + 32'd4;
    trap = 1'b0;
`ifdef PC_MISALIGN_TRAP_EN
    if (t[1]) begin
      trap = 1'b1;
      return TRAP_VEC;
    end
`endif
    return {t[31:2], 2'b00};
  endfunction

  task automatic run_instr(input logic [1:0] src, input logic [31:0] im, input logic [31:0] jt,
                           input int gd, input int rd, input int yd, input int xd);
    logic [31:0] word;
    logic [31:0] held;
    int n;
    n = 0;
    while (!imem_req && n < 20) begin
      tick();
      n++;
    end
    chk("req_seen", 32'(imem_req), 32'd1);
    chk("fetch_addr", imem_addr, model_pc);
    for (int i = 0; i < gd; i++) begin
      imem_gnt = 1'b0;
      redirect_valid = 1'($urandom_range(0, 1));
      pc_src = 2'($urandom_range(0, 3));
      tick();
      chk("gnt_stall_req", 32'(imem_req), 32'd1);
      chk("gnt_stall_addr", imem_addr, model_pc);
    end
    redirect_valid = 1'b0;
    imem_gnt = 1'b1;
    tick();
    imem_gnt = 1'b0;
    chk("req_drop", 32'(imem_req), 32'd0);
`ifdef PC_MISALIGN_TRAP_EN
    chk("trap_one_cycle", 32'(misalign_trap), 32'd0);
`endif
    for (int i = 0; i < rd; i++) begin
      redirect_valid = 1'($urandom_range(0, 1));
      pc_src = 2'($urandom_range(0, 3));
      tick();
      chk("wait_no_refetch", 32'(imem_req), 32'd0);
      chk("wait_pc_hold", pc, model_pc);
    end
    redirect_valid = 1'b0;
    word = $urandom;
    imem_rvalid = 1'b1;
    imem_rdata = word;
    tick();
    imem_rvalid = 1'b0;
    imem_rdata = $urandom;
    chk("inst_valid", 32'(inst_valid), 32'd1);
    chk("inst_word", inst, word);
    chk("inst_pc", inst_pc, model_pc);
    for (int i = 0; i < yd; i++) begin
      inst_ready = 1'b0;
      tick();
      chk("issue_hold_valid", 32'(inst_valid), 32'd1);
      chk("issue_hold_inst", inst, word);
      chk("issue_hold_pc", inst_pc, model_pc);
    end
    inst_ready = 1'b1;
    tick();
    inst_ready = 1'b0;
    chk("valid_drop", 32'(inst_valid), 32'd0);
    held = inst;
    for (int i = 0; i < xd; i++) begin
      imem_rvalid = 1'b1;
      imem_rdata = $urandom;
      tick();
      chk("exec_pc_hold", pc, model_pc);
      chk("exec_no_req", 32'(imem_req), 32'd0);
      chk("exec_ignore_rvalid", inst, held);
    end
    imem_rvalid = 1'b0;
    pc_src = src;
    imm = im;
    jalr_target = jt;
    redirect_valid = 1'b1;
    tick();
    redirect_valid = 1'b0;
    model_pc = model_next(model_pc, src, im, jt, model_trap);
    chk("next_pc", pc, model_pc);
    chk("next_req", 32'(imem_req), 32'd1);
`ifdef PC_MISALIGN_TRAP_EN
    chk("trap_pulse", 32'(misalign_trap), 32'(model_trap));
`endif
  endtask

  initial begin
    #2 rst_n = 1'b0;
    #1;
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_valid", 32'(inst_valid), 32'd0);
    chk("rst_inst", inst, NOP_WORD);
    chk("rst_inst_pc", inst_pc, RESET_VEC);
    chk("rst_pc", pc, RESET_VEC);
    #19 rst_n = 1'b1;
    #1;
    chk("boot_idle", 32'(imem_req), 32'd0);
    tick();
    chk("boot_req", 32'(imem_req), 32'd1);
    model_pc = RESET_VEC;

    // Sequential fetch 0x0, 0x4, 0x8, all handshakes immediate.
    for (int i = 0; i < 3; i++) run_instr(2'd0, 32'd0, 32'd0, 0, 0, 0, 0);
    chk("seq_addr_0xc", imem_addr, 32'h0000_000C);
    // Jump to 0x40, then branch back by 16.
    run_instr(2'd2, 32'd0, 32'h0000_0041, 0, 1, 0, 0);
    chk("jalr_0x40", imem_addr, 32'h0000_0040);
    run_instr(2'd1, 32'hFFFF_FFF0, 32'd0, 0, 0, 1, 0);
    chk("branch_0x30", imem_addr, 32'h0000_0030);
    run_instr(2'd2, 32'd0, 32'h0000_0201, 1, 0, 0, 1);
    chk("jalr_0x200", imem_addr, 32'h0000_0200);
    run_instr(2'd2, 32'd0, 32'h0000_0202, 0, 0, 0, 0);
`ifdef PC_MISALIGN_TRAP_EN
    chk("trap_vec", imem_addr, TRAP_VEC);
`else
    chk("jalr_0x202_aligned", imem_addr, 32'h0000_0200);
`endif
    // Wrap-around at the top of the address space.
    run_instr(2'd2, 32'd0, 32'hFFFF_FFFD, 0, 0, 0, 0);
    chk("top_addr", imem_addr, 32'hFFFF_FFFC);
    run_instr(2'd0, 32'd0, 32'd0, 0, 0, 0, 0);
    chk("wrap_zero", imem_addr, 32'h0000_0000);
    // Long grant and ready stalls.
    run_instr(2'd3, 32'd0, 32'd0, 3, 2, 4, 2);
    chk("rsvd_plus4", imem_addr, 32'h0000_0004);

    for (int k = 0; k < 40; k++) begin
      logic [1:0]  s;
      logic [31:0] im;
      logic [31:0] jt;
      s  = 2'($urandom_range(0, 3));
      im = 32'(int'($urandom_range(0, 511)) - 256) << 1;
      jt = $urandom;
      run_instr(s, im, jt, int'($urandom_range(0, 2)), int'($urandom_range(0, 2)),
                int'($urandom_range(0, 3)), int'($urandom_range(0, 2)));
    end

    // Reset while waiting for read data.
    begin
      int n;
      n = 0;
      while (!imem_req && n < 20) begin
        tick();
        n++;
      end
      chk("pre_rst_req", 32'(imem_req), 32'd1);
      imem_gnt = 1'b1;
      tick();
      imem_gnt = 1'b0;
      #3 rst_n = 1'b0;
      #1;
      chk("async_rst_req", 32'(imem_req), 32'd0);
      chk("async_rst_pc", pc, RESET_VEC);
      chk("async_rst_inst", inst, NOP_WORD);
      chk("async_rst_inst_pc", inst_pc, RESET_VEC);
      chk("async_rst_valid", 32'(inst_valid), 32'd0);
      repeat (2) @(posedge clk);
      #3 rst_n = 1'b1;
      #1;
      chk("post_rst_boot", 32'(imem_req), 32'd0);
      tick();
      chk("post_rst_req", 32'(imem_req), 32'd1);
      chk("post_rst_addr", imem_addr, RESET_VEC);
      model_pc = RESET_VEC;
      run_instr(2'd0, 32'd0, 32'd0, 0, 0, 0, 0);
      chk("post_rst_next", imem_addr, 32'h0000_0004);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
